// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS Avalon-MM bus arbiter.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUS,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } port_id_t;

  // Full-word byte enables used for every instruction fetch on a 32-bit bus
  localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/arb_rr2.sv
// Two-way grant selection between instruction fetch and load/store.
// Build option MIPS_ARB_DATA_PRIORITY_EN: the D-port wins every tie instead of
// alternating with the I-port.
module arb_rr2 import mips_bus_pkg::*; (
  input  logic     i_req_i,
  input  logic     d_req_i,
  input  port_id_t last_grant_i,
  output logic     valid_o,
  output port_id_t grant_o
);

`ifdef MIPS_ARB_DATA_PRIORITY_EN
  // History is still tracked by the caller but plays no part in a tie here
  logic unused_last_grant;
  assign unused_last_grant = (last_grant_i == PORT_D);
`endif

  // Pick the winner; a lone requester always wins
  always_comb begin
    valid_o = i_req_i | d_req_i;
    grant_o = PORT_I;
    if (i_req_i && d_req_i) begin
`ifdef MIPS_ARB_DATA_PRIORITY_EN
      grant_o = PORT_D;
`else
      grant_o = (last_grant_i == PORT_D) ? PORT_I : PORT_D;
`endif
    end else if (d_req_i) begin
      grant_o = PORT_D;
    end
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares the core's single Avalon-MM master between instruction fetch (I-port)
// and load/store (D-port). One transfer at a time: IDLE grants and latches,
// BUS holds the strobes until waitrequest drops, RESP pulses the ack.
// Build option MIPS_ARB_DATA_PRIORITY_EN (applied in arb_rr2) gives the D-port
// fixed priority on ties.
module mips_bus_arbiter import mips_bus_pkg::*; #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  // Instruction fetch port
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  // Load/store port
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  // Avalon-MM master
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic                waitrequest,
  input  logic [DATA_W-1:0]   readdata
);

  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_t          state_q;
  port_id_t            grant_q;
  port_id_t            last_grant_q;
  port_id_t            win;
  logic                any_req;
  logic [ADDR_W-1:0]   address_q;
  logic                read_q;
  logic                write_q;
  logic [DATA_W-1:0]   writedata_q;
  logic [BE_W-1:0]     byteenable_q;
  logic [DATA_W-1:0]   i_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                i_ack_q;
  logic                d_ack_q;

  arb_rr2 u_arb (
    .i_req_i      (i_req),
    .d_req_i      (d_req),
    .last_grant_i (last_grant_q),
    .valid_o      (any_req),
    .grant_o      (win)
  );

  // Transfer sequencer; every bus and response output comes straight from a register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB_IDLE;
      grant_q      <= PORT_I;
      last_grant_q <= PORT_D;  // first tie goes to the I-port
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (any_req) begin
            grant_q      <= win;
            last_grant_q <= win;
            if (win == PORT_I) begin
              address_q    <= i_addr;
              read_q       <= 1'b1;
              write_q      <= 1'b0;
              writedata_q  <= '0;
              byteenable_q <= '1;
            end else begin
              address_q    <= d_addr;
              read_q       <= ~d_we;
              write_q      <= d_we;
              writedata_q  <= d_wdata;
              byteenable_q <= d_be;
            end
            state_q <= ARB_BUS;
          end
        end
        ARB_BUS: begin
          if (!waitrequest) begin
            if (read_q) begin
              if (grant_q == PORT_I) i_rdata_q <= readdata;
              else                   d_rdata_q <= readdata;
            end
            read_q  <= 1'b0;
            write_q <= 1'b0;
            i_ack_q <= (grant_q == PORT_I);
            d_ack_q <= (grant_q == PORT_D);
            state_q <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          i_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          state_q <= ARB_IDLE;
        end
        default: begin
          read_q  <= 1'b0;
          write_q <= 1'b0;
          i_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign i_ack      = i_ack_q;
  assign d_ack      = d_ack_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: the bench plays both requesters and the Avalon
// slave, and predicts grants and returned data from a transaction-level model.
module tb_mips_bus_arbiter;
  import mips_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = '0;

  int checks = 0;
  int errors = 0;

  // Model: who was granted last (0 = I, 1 = D) and each port's last read word
  int          model_last = 1;
  logic [31:0] m_i_rdata = '0;
  logic [31:0] m_d_rdata = '0;

  mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_ack       (i_ack),
    .i_rdata     (i_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_be        (d_be),
    .d_ack       (d_ack),
    .d_rdata     (d_rdata),
    .address     (address),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .waitrequest (waitrequest),
    .readdata    (readdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Winner chosen by the arbitration rules: 0 = I, 1 = D
  function automatic int pick(input logic ir, input logic dr);
    if (ir && dr) begin
`ifdef MIPS_ARB_DATA_PRIORITY_EN
      return 1;
`else
      return (model_last == 1) ? 0 : 1;
`endif
    end
    return ir ? 0 : 1;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({read, write} !== 2'b00) begin
      errors++; $display("FAIL reset_strobes got %b want 00", {read, write});
    end
    checks++;
    if ({address, writedata, byteenable} !== 68'd0) begin
      errors++; $display("FAIL reset_bus got %h/%h/%h want 0", address, writedata, byteenable);
    end
    checks++;
    if ({i_ack, d_ack, i_rdata, d_rdata} !== 66'd0) begin
      errors++; $display("FAIL reset_resp got %b%b %h %h want 0", i_ack, d_ack, i_rdata, d_rdata);
    end
    reset = 1'b1;
    model_last = 1;
    m_i_rdata = '0;
    m_d_rdata = '0;
    tick();
  endtask

  task automatic test_i_single();
    i_addr = 32'hBFC0_0000;
    readdata = 32'h2402_0005;
    waitrequest = 1'b0;
    i_req = 1'b1;
    tick();
    checks++;
    if ({read, write, address, byteenable} !== {2'b10, 32'hBFC0_0000, BE_ALL}) begin
      errors++; $display("FAIL i_single_bus got rw=%b addr=%h be=%h want 10 bfc00000 f",
                         {read, write}, address, byteenable);
    end
    tick();
    checks++;
    if ({i_ack, d_ack, read, i_rdata} !== {3'b100, 32'h2402_0005}) begin
      errors++; $display("FAIL i_single_ack got ack=%b%b rd=%b data=%h want 10 0 24020005",
                         i_ack, d_ack, read, i_rdata);
    end
    i_req = 1'b0;
    m_i_rdata = 32'h2402_0005;
    model_last = 0;
    tick();
    checks++;
    if ({i_ack, read} !== 2'b00) begin
      errors++; $display("FAIL i_single_idle got ack=%b rd=%b want 0 0", i_ack, read);
    end
  endtask

  task automatic test_d_write_stall();
    int acks = 0;
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h0000_1000;
    d_wdata = 32'hDEAD_BEEF;
    d_be = 4'b0011;
    waitrequest = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      waitrequest = (c < 3);
      checks++;
      if ({write, read, address, writedata, byteenable, d_ack} !==
          {2'b10, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011, 1'b0}) begin
        errors++; $display("FAIL d_write_hold c=%0d got wr=%b rd=%b a=%h wd=%h be=%h ack=%b",
                           c, write, read, address, writedata, byteenable, d_ack);
      end
      tick();
    end
    acks += d_ack;
    checks++;
    if ({d_ack, i_ack, write, read} !== 4'b1000) begin
      errors++; $display("FAIL d_write_ack got ack=%b%b wr=%b rd=%b want 1 0 0 0",
                         d_ack, i_ack, write, read);
    end
    d_req = 1'b0;
    model_last = 1;
    tick();
    acks += d_ack;
    tick();
    acks += d_ack;
    checks++;
    if (acks !== 1 || d_rdata !== m_d_rdata) begin
      errors++; $display("FAIL d_write_single got acks=%0d rdata=%h want 1 %h",
                         acks, d_rdata, m_d_rdata);
    end
  endtask

  task automatic test_tie();
    int exp;
    logic [31:0] rd;
    d_we = 1'b0;
    d_be = 4'b1111;
    i_addr = $urandom;
    d_addr = $urandom;
    i_req = 1'b1;
    d_req = 1'b1;
    for (int r = 0; r < 4; r++) begin
      exp = pick(i_req, d_req);
      rd = $urandom;
      tick();
      checks++;
      if ({read, write, address} !== {2'b10, (exp == 1) ? d_addr : i_addr}) begin
        errors++; $display("FAIL tie_grant r=%0d got rw=%b addr=%h want port %0d",
                           r, {read, write}, address, exp);
      end
      readdata = rd;
      waitrequest = 1'b0;
      tick();
      model_last = exp;
      if (exp == 1) m_d_rdata = rd; else m_i_rdata = rd;
      checks++;
      if ({i_ack, d_ack, i_rdata, d_rdata} !==
          {(exp == 0), (exp == 1), m_i_rdata, m_d_rdata}) begin
        errors++; $display("FAIL tie_ack r=%0d got ack=%b%b i=%h d=%h want port %0d i=%h d=%h",
                           r, i_ack, d_ack, i_rdata, d_rdata, exp, m_i_rdata, m_d_rdata);
      end
      if (r == 3) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end else if (exp == 1) d_req = 1'b0;
      else i_req = 1'b0;
      tick();
      if (r < 3) begin
        if (exp == 1) begin d_req = 1'b1; d_addr = $urandom; end
        else begin i_req = 1'b1; i_addr = $urandom; end
      end
    end
  endtask

  task automatic test_d_then_i();
    logic [31:0] rd;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = $urandom;
    waitrequest = 1'b1;
    tick();
    i_req = 1'b1;
    i_addr = $urandom;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if ({read, address, i_ack, d_ack} !== {1'b1, d_addr, 2'b00}) begin
        errors++; $display("FAIL dti_hold c=%0d got rd=%b addr=%h ack=%b%b want 1 %h 00",
                           c, read, address, i_ack, d_ack, d_addr);
      end
      tick();
    end
    rd = $urandom;
    readdata = rd;
    waitrequest = 1'b0;
    tick();
    m_d_rdata = rd;
    model_last = 1;
    checks++;
    if ({i_ack, d_ack, d_rdata} !== {2'b01, rd}) begin
      errors++; $display("FAIL dti_dack got ack=%b%b d=%h want 01 %h", i_ack, d_ack, d_rdata, rd);
    end
    d_req = 1'b0;
    tick();
    checks++;
    if ({i_ack, d_ack, read} !== 3'b000) begin
      errors++; $display("FAIL dti_gap got ack=%b%b rd=%b want 000", i_ack, d_ack, read);
    end
    tick();
    checks++;
    if ({read, address} !== {1'b1, i_addr}) begin
      errors++; $display("FAIL dti_igrant got rd=%b addr=%h want 1 %h", read, address, i_addr);
    end
    rd = $urandom;
    readdata = rd;
    tick();
    m_i_rdata = rd;
    model_last = 0;
    checks++;
    if ({i_ack, d_ack, i_rdata} !== {2'b10, rd}) begin
      errors++; $display("FAIL dti_iack got ack=%b%b i=%h want 10 %h", i_ack, d_ack, i_rdata, rd);
    end
    i_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    logic [31:0] rd;
    i_req = 1'b1;
    i_addr = $urandom;
    waitrequest = 1'b1;
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({read, write} !== 2'b00) begin
      errors++; $display("FAIL rst_mid_drop got rw=%b want 00", {read, write});
    end
    i_req = 1'b0;
    waitrequest = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      acks += i_ack + d_ack;
    end
    reset = 1'b1;
    model_last = 1;
    m_i_rdata = '0;
    m_d_rdata = '0;
    tick();
    acks += i_ack + d_ack;
    checks++;
    if (acks !== 0 || i_rdata !== 32'd0) begin
      errors++; $display("FAIL rst_mid_noack got acks=%0d i=%h want 0 0", acks, i_rdata);
    end
    rd = $urandom;
    readdata = rd;
    i_addr = $urandom;
    i_req = 1'b1;
    tick();
    checks++;
    if ({read, address} !== {1'b1, i_addr}) begin
      errors++; $display("FAIL rst_mid_regrant got rd=%b addr=%h want 1 %h", read, address, i_addr);
    end
    tick();
    m_i_rdata = rd;
    model_last = 0;
    checks++;
    if ({i_ack, i_rdata} !== {1'b1, rd}) begin
      errors++; $display("FAIL rst_mid_ack got ack=%b i=%h want 1 %h", i_ack, i_rdata, rd);
    end
    i_req = 1'b0;
    tick();
  endtask

  task automatic test_readdata_stall();
    int n;
    logic [31:0] fin;
    n = $urandom_range(2, 5);
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = $urandom;
    waitrequest = 1'b1;
    tick();
    for (int c = 0; c < n; c++) begin
      readdata = $urandom;
      tick();
    end
    fin = $urandom;
    readdata = fin;
    waitrequest = 1'b0;
    tick();
    readdata = ~fin;
    m_d_rdata = fin;
    model_last = 1;
    checks++;
    if ({d_ack, d_rdata} !== {1'b1, fin}) begin
      errors++; $display("FAIL rdata_stall got ack=%b d=%h want 1 %h", d_ack, d_rdata, fin);
    end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int exp;
    int n;
    logic [31:0] e_addr, e_wd, rd;
    logic [3:0]  e_be;
    logic        e_wr;
    for (int t = 0; t < 30; t++) begin
      if (!i_req && $urandom_range(0, 1) == 1) begin i_req = 1'b1; i_addr = $urandom; end
      if (!d_req && $urandom_range(0, 1) == 1) begin
        d_req = 1'b1; d_we = $urandom_range(0, 1); d_addr = $urandom;
        d_wdata = $urandom; d_be = $urandom_range(1, 15);
      end
      if (!i_req && !d_req) begin i_req = 1'b1; i_addr = $urandom; end
      exp = pick(i_req, d_req);
      e_addr = (exp == 1) ? d_addr : i_addr;
      e_wr   = (exp == 1) ? d_we : 1'b0;
      e_be   = (exp == 1) ? d_be : BE_ALL;
      e_wd   = d_wdata;
      rd     = '0;
      n = $urandom_range(0, 3);
      tick();
      for (int c = 0; c <= n; c++) begin
        waitrequest = (c < n);
        readdata = $urandom;
        if (c == n) rd = readdata;
        checks++;
        if ({read, write, address, byteenable} !== {~e_wr, e_wr, e_addr, e_be} ||
            (e_wr && writedata !== e_wd)) begin
          errors++; $display("FAIL rand_bus t=%0d got rw=%b a=%h be=%h wd=%h want %b %h %h %h",
                             t, {read, write}, address, byteenable, writedata,
                             {~e_wr, e_wr}, e_addr, e_be, e_wd);
        end
        tick();
      end
      if (!e_wr) begin
        if (exp == 1) m_d_rdata = rd; else m_i_rdata = rd;
      end
      model_last = exp;
      checks++;
      if ({i_ack, d_ack, i_rdata, d_rdata} !==
          {(exp == 0), (exp == 1), m_i_rdata, m_d_rdata}) begin
        errors++; $display("FAIL rand_resp t=%0d got ack=%b%b i=%h d=%h want port %0d i=%h d=%h",
                           t, i_ack, d_ack, i_rdata, d_rdata, exp, m_i_rdata, m_d_rdata);
      end
      if (exp == 1) d_req = 1'b0; else i_req = 1'b0;
      tick();
    end
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_i_single();
    test_d_write_stall();
    test_tie();
    test_d_then_i();
    test_reset_mid();
    test_readdata_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
